// File: rtl/bip_control.sv
// BIP control unit: program counter, instruction register and fetch/execute
// sequencer that decodes each instruction into datapath selects and strobes.
module bip_control #(
  parameter int N_BUS    = 16,
  parameter int N_OPCODE = 5,
  parameter int N_ADDR   = 11
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [N_BUS-1:0]  i_instr,
  output logic [N_ADDR-1:0] o_PC,
  output logic [N_ADDR-1:0] o_OPERAND,
  output logic [1:0]        o_selA,
  output logic              o_selB,
  output logic              o_OP,
  output logic              o_wrAcc,
  output logic              o_wrRam,
  output logic              o_rdRam,
  output logic              o_halt,
  output logic [N_BUS-1:0]  o_inst_count
);

  // state   | meaning
  // S_IDLE  | waiting for i_enable at an instruction boundary
  // S_FETCH | IR loads mem[PC]
  // S_EXEC  | decoded strobes active, PC/count advance
  // S_HALT  | HLT executed, only reset leaves
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [N_OPCODE-1:0] OPC_HLT  = N_OPCODE'(0);
  localparam logic [N_OPCODE-1:0] OPC_STO  = N_OPCODE'(1);
  localparam logic [N_OPCODE-1:0] OPC_LD   = N_OPCODE'(2);
  localparam logic [N_OPCODE-1:0] OPC_LDI  = N_OPCODE'(3);
  localparam logic [N_OPCODE-1:0] OPC_ADD  = N_OPCODE'(4);
  localparam logic [N_OPCODE-1:0] OPC_ADDI = N_OPCODE'(5);
  localparam logic [N_OPCODE-1:0] OPC_SUB  = N_OPCODE'(6);
  localparam logic [N_OPCODE-1:0] OPC_SUBI = N_OPCODE'(7);

  state_t              state, state_next;
  logic [N_BUS-1:0]    ir;
  logic [N_ADDR-1:0]   pc;
  logic [N_BUS-1:0]    inst_count;
  logic [N_OPCODE-1:0] opcode;

  assign opcode = ir[N_BUS-1 -: N_OPCODE];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      ir         <= '0;
      pc         <= '0;
      inst_count <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH) ir <= i_instr;
      if (state == S_EXEC && opcode != OPC_HLT) begin
        pc <= pc + 1'b1;
        if (inst_count != '1) inst_count <= inst_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = i_enable ? S_FETCH : S_IDLE;
      S_FETCH: state_next = i_enable ? S_EXEC : S_IDLE;
      S_EXEC:  begin
        if (opcode == OPC_HLT) state_next = S_HALT;
        else                   state_next = i_enable ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Reset gates every strobe combinationally so nothing fires during a reset cycle.
  always_comb begin
    o_selA  = 2'd0;
    o_selB  = 1'b0;
    o_OP    = 1'b0;
    o_wrAcc = 1'b0;
    o_wrRam = 1'b0;
    o_rdRam = 1'b0;
    o_halt  = 1'b0;
    if (!i_reset) begin
      o_halt = (state == S_HALT);
      if (state == S_EXEC) begin
        case (opcode)
          OPC_STO:  o_wrRam = 1'b1;
          OPC_LD:   begin o_wrAcc = 1'b1; o_rdRam = 1'b1; end
          OPC_LDI:  begin o_selA = 2'd1; o_wrAcc = 1'b1; end
          OPC_ADD:  begin o_selA = 2'd2; o_wrAcc = 1'b1; o_rdRam = 1'b1; end
          OPC_ADDI: begin o_selA = 2'd2; o_selB = 1'b1; o_wrAcc = 1'b1; end
          OPC_SUB:  begin o_selA = 2'd2; o_OP = 1'b1; o_wrAcc = 1'b1; o_rdRam = 1'b1; end
          OPC_SUBI: begin o_selA = 2'd2; o_selB = 1'b1; o_OP = 1'b1; o_wrAcc = 1'b1; end
          default:  ;
        endcase
      end
    end
  end

  assign o_PC         = pc;
  assign o_OPERAND    = ir[N_ADDR-1:0];
  assign o_inst_count = inst_count;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: directed programs plus random programs/enables,
// every cycle compared against an instruction-level reference model.
module tb_bip_control;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic [15:0] i_instr;
  logic [10:0] o_PC, o_OPERAND;
  logic [1:0]  o_selA;
  logic        o_selB, o_OP, o_wrAcc, o_wrRam, o_rdRam, o_halt;
  logic [15:0] o_inst_count;

  logic [15:0] mem [0:2047];
  int total = 0;
  int bad = 0;

  // reference model: phase 0 idle, 1 fetch, 2 exec, 3 halted
  int          m_phase;
  logic [10:0] m_pc;
  logic [15:0] m_ir;
  int          m_count;

  bip_control dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_instr(i_instr),
    .o_PC(o_PC), .o_OPERAND(o_OPERAND), .o_selA(o_selA), .o_selB(o_selB),
    .o_OP(o_OP), .o_wrAcc(o_wrAcc), .o_wrRam(o_wrRam), .o_rdRam(o_rdRam),
    .o_halt(o_halt), .o_inst_count(o_inst_count)
  );

  always #5 i_clk = ~i_clk;
  assign i_instr = mem[o_PC];

  // {selA, selB, OP, wrAcc, wrRam, rdRam} per mnemonic
  function automatic logic [6:0] decode(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_0_1_0;
      5'd2:    return 7'b00_0_0_1_0_1;
      5'd3:    return 7'b01_0_0_1_0_0;
      5'd4:    return 7'b10_0_0_1_0_1;
      5'd5:    return 7'b10_1_0_1_0_0;
      5'd6:    return 7'b10_0_1_1_0_1;
      5'd7:    return 7'b10_1_1_1_0_0;
      default: return 7'b0;
    endcase
  endfunction

  function automatic logic [15:0] ins(input int opc, input int operand);
    return {opc[4:0], operand[10:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_nop();
    for (int a = 0; a < 2048; a++) mem[a] = 16'h4000;
  endtask

  // Drive inputs, compare this cycle's outputs with the model, then clock both.
  task automatic tick(input logic rst, input logic en);
    logic [6:0] exp_ctrl;
    i_reset  = rst;
    i_enable = en;
    #1;
    exp_ctrl = (!rst && m_phase == 2) ? decode(m_ir[15:11]) : 7'b0;
    chk("pc", 32'(o_PC), 32'(m_pc));
    chk("operand", 32'(o_OPERAND), 32'(m_ir[10:0]));
    chk("ctrl", 32'({o_selA, o_selB, o_OP, o_wrAcc, o_wrRam, o_rdRam}), 32'(exp_ctrl));
    chk("halt", 32'(o_halt), 32'(!rst && m_phase == 3));
    chk("count", 32'(o_inst_count), 32'(m_count));
    @(posedge i_clk);
    if (rst) begin
      m_phase = 0; m_pc = '0; m_ir = '0; m_count = 0;
    end else begin
      case (m_phase)
        0: if (en) m_phase = 1;
        1: begin m_ir = mem[m_pc]; m_phase = en ? 2 : 0; end
        2: begin
          if (m_ir[15:11] == 5'd0) m_phase = 3;
          else begin
            m_pc = m_pc + 11'd1;
            if (m_count < 65535) m_count++;
            m_phase = en ? 1 : 0;
          end
        end
        default: m_phase = 3;
      endcase
    end
    #1;
  endtask

  task automatic run(input int n, input logic en);
    for (int k = 0; k < n; k++) tick(1'b0, en);
  endtask

  initial begin
    m_phase = 0; m_pc = '0; m_ir = '0; m_count = 0;
    fill_nop();
    @(posedge i_clk); #1;

    // T1: LDI 5, ADDI 3, STO 7, HLT
    mem[0] = ins(3, 5); mem[1] = ins(5, 3); mem[2] = ins(1, 7); mem[3] = ins(0, 0);
    tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    run(12, 1'b1);
    chk("t1_halt", 32'(o_halt), 32'd1);
    chk("t1_pc", 32'(o_PC), 32'd3);
    chk("t1_count", 32'(o_inst_count), 32'd3);
    // reset out of halt
    tick(1'b1, 1'b0);
    chk("t6_halt_clear", 32'(o_halt), 32'd0);

    // T2: LD 4, SUB 5, SUBI 1, HLT
    mem[0] = ins(2, 4); mem[1] = ins(6, 5); mem[2] = ins(7, 1); mem[3] = ins(0, 0);
    tick(1'b1, 1'b1);
    run(10, 1'b1);
    chk("t2_count", 32'(o_inst_count), 32'd3);

    // T3: drop enable during EXEC of the second instruction
    mem[0] = ins(3, 1); mem[1] = ins(3, 2); mem[2] = ins(4, 9); mem[3] = ins(0, 0);
    tick(1'b1, 1'b0);
    run(4, 1'b1);
    run(4, 1'b0);
    chk("t3_pc_stop", 32'(o_PC), 32'd2);
    chk("t3_idle_nostrobe", 32'({o_wrAcc, o_wrRam, o_rdRam}), 32'd0);
    run(8, 1'b1);
    chk("t3_resume_halt", 32'(o_halt), 32'd1);

    // T4: opcode 11111 is a NOP
    fill_nop();
    mem[0] = 16'hF800; mem[1] = ins(0, 0);
    tick(1'b1, 1'b0);
    run(3, 1'b1);
    chk("t4_pc", 32'(o_PC), 32'd1);
    chk("t4_count", 32'(o_inst_count), 32'd1);

    // T5: PC wraps after 2048 NOPs
    fill_nop();
    tick(1'b1, 1'b0);
    run(1 + 2 * 2048, 1'b1);
    chk("t5_pc_wrap", 32'(o_PC), 32'd0);
    chk("t5_count", 32'(o_inst_count), 32'd2048);

    // T6: reset in EXEC of STO suppresses the write
    mem[0] = ins(1, 7);
    tick(1'b1, 1'b0);
    run(2, 1'b1);
    i_reset = 1'b1; #1;
    chk("t6_wrram_masked", 32'(o_wrRam), 32'd0);
    tick(1'b1, 1'b1);
    chk("t6_pc", 32'(o_PC), 32'd0);
    chk("t6_count", 32'(o_inst_count), 32'd0);

    // random programs, enables and occasional resets
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 2048; a++) begin
        int opc;
        opc = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 31);
        mem[a] = ins(opc, $urandom_range(0, 2047));
      end
      tick(1'b1, 1'b0);
      for (int k = 0; k < 600; k++)
        tick($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 85);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
